// File: rtl/audio_sample_frontend.sv
// audio_sample_frontend
//   Bridges the audio codec read port to the ColorChord DFT sample input.
//   Each codec sample pair is popped with a single codecRead pulse, summed
//   (L+R), scaled by 2^-8 with saturation to 16 bits, and queued in a small
//   FIFO that the DFT drains with doingRead. A decaying peak meter drives
//   the LED level output.
//
//   Optional feature: define SAMPLE_DC_BLOCK_EN to insert a DC-blocking
//   high-pass stage after saturation (one extra cycle of latency).
//
// Ports
//   clk          single clock for both codec and DFT sides
//   rst          synchronous, active-high reset
//   codecReady   codec has a sample pair available
//   codecLeft    signed 24-bit left sample
//   codecRight   signed 24-bit right sample
//   codecRead    one-cycle pop pulse to the codec
//   doingRead    DFT pops the head sample this cycle
//   sampleReady  FIFO non-empty
//   inputSample  signed 16-bit head of FIFO (holds last head when empty)
//   level        10-bit decaying peak level
//   overflow     sticky: a sample was waiting while the FIFO was full
module audio_sample_frontend #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DECAY_SHIFT = 4,
  parameter int unsigned DC_SHIFT    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        codecReady,
  input  logic [23:0] codecLeft,
  input  logic [23:0] codecRight,
  output logic        codecRead,
  input  logic        doingRead,
  output logic        sampleReady,
  output logic [15:0] inputSample,
  output logic [9:0]  level,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if ((DC_SHIFT < 1) || (DC_SHIFT > 15)) begin : g_dc_chk
    $error("DC_SHIFT must be in 1..15");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  function automatic logic [15:0] sat17(input logic [16:0] v);
    if (v[16] != v[15]) sat17 = v[16] ? 16'h8000 : 16'h7FFF;
    else                sat17 = v[15:0];
  endfunction

  state_t        state_q, state_d;
  logic          codec_read_q, codec_read_d;
  logic [23:0]   lat_l_q, lat_l_d;
  logic [23:0]   lat_r_q, lat_r_d;
  logic          lat_valid_q, lat_valid_d;
  logic [15:0]   cond_q, cond_d;
  logic          cond_valid_q, cond_valid_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   last_q, last_d;
  logic [9:0]    level_q, level_d;
  logic          overflow_q, overflow_d;

  logic [24:0]   sum;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic          pop;
  logic [OW-1:0] occ;
  logic [15:0]   mag;
  logic [9:0]    lev_a;
  logic [9:0]    lev_decay;

`ifdef SAMPLE_DC_BLOCK_EN
  localparam int unsigned ACCW = 16 + DC_SHIFT;

  logic [ACCW-1:0] acc_q, acc_d;
  logic [15:0]     dc_q, dc_d;
  logic            dc_valid_q, dc_valid_d;
  logic [15:0]     acc_fb;
  logic [16:0]     dc_diff;

  // acc tracks the DC component scaled by 2^DC_SHIFT; acc_fb is the
  // current DC estimate subtracted from the sample.
  always_comb begin
    acc_fb     = 16'($signed(acc_q) >>> DC_SHIFT);
    dc_diff    = {cond_q[15], cond_q} - {acc_fb[15], acc_fb};
    acc_d      = acc_q;
    dc_d       = dc_q;
    dc_valid_d = cond_valid_q;
    if (cond_valid_q) begin
      acc_d = acc_q + {{(ACCW-16){cond_q[15]}}, cond_q}
                    - {{(ACCW-16){acc_fb[15]}}, acc_fb};
      dc_d  = sat17(dc_diff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      dc_q       <= '0;
      dc_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      dc_q       <= dc_d;
      dc_valid_q <= dc_valid_d;
    end
  end

  assign wr_en   = dc_valid_q;
  assign wr_data = dc_q;
  assign occ     = {1'b0, count_q} + OW'(lat_valid_q) + OW'(cond_valid_q)
                 + OW'(dc_valid_q);
`else
  assign wr_en   = cond_valid_q;
  assign wr_data = cond_q;
  assign occ     = {1'b0, count_q} + OW'(lat_valid_q) + OW'(cond_valid_q);
`endif

  // Capture FSM: occupancy includes samples still in the pipeline so the
  // FIFO can never be overrun by an already-issued read.
  always_comb begin
    state_d      = state_q;
    codec_read_d = 1'b0;
    lat_valid_d  = 1'b0;
    lat_l_d      = lat_l_q;
    lat_r_d      = lat_r_q;
    overflow_d   = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (codecReady) begin
          if (occ < OW'(DEPTH)) begin
            codec_read_d = 1'b1;
            lat_valid_d  = 1'b1;
            lat_l_d      = codecLeft;
            lat_r_d      = codecRight;
            state_d      = S_HOLD;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_HOLD: state_d = S_IDLE;
    endcase
  end

  // Conditioning: 25-bit sum, arithmetic shift by 8, saturate to 16 bits.
  always_comb begin
    sum          = {lat_l_q[23], lat_l_q} + {lat_r_q[23], lat_r_q};
    cond_valid_d = lat_valid_q;
    cond_d       = cond_q;
    if (lat_valid_q) cond_d = sat17(17'($signed(sum) >>> 8));
  end

  // FIFO
  always_comb begin
    pop      = doingRead && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
  end

  // Level meter: -32768 has no positive 16-bit magnitude, so clamp it.
  always_comb begin
    if (wr_data == 16'h8000)  mag = 16'h7FFF;
    else if (wr_data[15])     mag = -wr_data;
    else                      mag = wr_data;
    lev_a     = 10'(mag >> 6);
    lev_decay = level_q - (level_q >> DECAY_SHIFT);
    level_d   = level_q;
    if (wr_en) level_d = (lev_a > lev_decay) ? lev_a : lev_decay;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      codec_read_q <= 1'b0;
      lat_l_q      <= '0;
      lat_r_q      <= '0;
      lat_valid_q  <= 1'b0;
      cond_q       <= '0;
      cond_valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_q       <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      codec_read_q <= codec_read_d;
      lat_l_q      <= lat_l_d;
      lat_r_q      <= lat_r_d;
      lat_valid_q  <= lat_valid_d;
      cond_q       <= cond_d;
      cond_valid_q <= cond_valid_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_q       <= last_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
    end
  end

  assign codecRead   = codec_read_q;
  assign sampleReady = (count_q != '0);
  assign inputSample = sampleReady ? mem_q[rd_ptr_q] : last_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_audio_sample_frontend.sv
// tb_audio_sample_frontend
//   Directed bench for audio_sample_frontend with a behavioural codec
//   source and a scoreboard of expected FIFO output samples.
module tb_audio_sample_frontend;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        codecReady;
  logic [23:0] codecLeft;
  logic [23:0] codecRight;
  logic        codecRead;
  logic        doingRead;
  logic        sampleReady;
  logic [15:0] inputSample;
  logic [9:0]  level;
  logic        overflow;

  audio_sample_frontend #(.DEPTH(DEPTH), .DECAY_SHIFT(4), .DC_SHIFT(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .codecReady (codecReady),
    .codecLeft  (codecLeft),
    .codecRight (codecRight),
    .codecRead  (codecRead),
    .doingRead  (doingRead),
    .sampleReady(sampleReady),
    .inputSample(inputSample),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic prev_read = 1'b0;
  int level_m = 0;

  logic [23:0] lq[$];
  logic [23:0] rq[$];
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sample(input logic [23:0] l, input logic [23:0] r);
    int sl, sr, s;
    sl = $signed(l);
    sr = $signed(r);
    s  = (sl + sr) >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic void model_level(input logic [15:0] v);
    int sv, a, d;
    sv = $signed(v);
    a  = (sv < 0) ? -sv : sv;
    if (a > 32767) a = 32767;
    a = a >> 6;
    d = level_m - (level_m >> 4);
    level_m = (a > d) ? a : d;
  endfunction

  task automatic drive_codec();
    codecReady = (lq.size() > 0);
    codecLeft  = (lq.size() > 0) ? lq[0] : 24'h0;
    codecRight = (rq.size() > 0) ? rq[0] : 24'h0;
  endtask

  task automatic enqueue(input logic [23:0] l, input logic [23:0] r);
    logic [15:0] e;
    e = model_sample(l, r);
    lq.push_back(l);
    rq.push_back(r);
    sb.push_back(e);
    model_level(e);
    drive_codec();
  endtask

  // Advance one cycle and sample 1 time unit after the edge. A visible
  // codecRead means the codec pair was taken on the edge just passed.
  task automatic tick();
    @(posedge clk);
    #1;
    if (codecRead === 1'b1) begin
      pulses++;
      chk("read_spacing", {31'b0, prev_read}, 32'd0);
      if (lq.size() > 0) begin
        void'(lq.pop_front());
        void'(rq.pop_front());
      end
    end
    prev_read = (codecRead === 1'b1);
    drive_codec();
  endtask

  task automatic wait_read(input int n);
    int p0;
    p0 = pulses;
    for (int i = 0; i < n && pulses == p0; i++) tick();
    chk("read_seen", {31'b0, pulses != p0}, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    chk("pop_ready", {31'b0, sampleReady}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      e = 16'h0;
    end else begin
      e = sb.pop_front();
    end
    chk(tag, {16'b0, inputSample}, {16'b0, e});
    doingRead = 1'b1;
    tick();
    doingRead = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [31:0] rnd;
    rst = 1'b1;
    doingRead = 1'b0;
    drive_codec();
    repeat (3) tick();
    chk("rst_codecRead",   {31'b0, codecRead},   32'd0);
    chk("rst_sampleReady", {31'b0, sampleReady}, 32'd0);
    chk("rst_inputSample", {16'b0, inputSample}, 32'd0);
    chk("rst_level",       {22'b0, level},       32'd0);
    chk("rst_overflow",    {31'b0, overflow},    32'd0);
    rst = 1'b0;
    tick();

    // First sample: latency from codecRead to sampleReady is 2 cycles.
    enqueue(24'h000100, 24'h000100);
    wait_read(10);
    tick();
    chk("lat_not_ready_1", {31'b0, sampleReady}, 32'd0);
    tick();
    chk("lat_ready_2", {31'b0, sampleReady}, 32'd1);
    pop_check("sample_0002");

    // Positive and negative saturation, level meter at full scale.
    enqueue(24'h7FFFFF, 24'h7FFFFF);
    enqueue(24'h800000, 24'h800000);
    repeat (12) tick();
    chk("level_full", {22'b0, level}, level_m[31:0]);
    chk("level_1ff",  {22'b0, level}, 32'h1FF);
    pop_check("sat_pos");
    pop_check("sat_neg");
    chk("empty_after_drain", {31'b0, sampleReady}, 32'd0);
    chk("hold_last_head",    {16'b0, inputSample}, 32'h8000);
    chk("no_overflow_yet",   {31'b0, overflow},    32'd0);

    // Fill: codecReady held, no pops -> exactly DEPTH pulses then overflow.
    p0 = pulses;
    for (int i = 0; i < DEPTH + 1; i++) begin
      rnd = $urandom();
      enqueue(rnd[23:0], rnd[31:8]);
    end
    repeat (40) tick();
    chk("fill_pulses", pulses - p0, DEPTH);
    chk("fill_overflow", {31'b0, overflow}, 32'd1);

    // One pop frees a slot: exactly one more capture.
    p0 = pulses;
    pop_check("refill_pop");
    repeat (10) tick();
    chk("refill_pulses", pulses - p0, 32'd1);
    chk("refill_level", {22'b0, level}, level_m[31:0]);

    // Drain down to three entries.
    for (int i = 0; i < DEPTH - 3; i++) pop_check("drain_order");

    // Write and pop on the same edge at count=3.
    enqueue(24'hFF0000, 24'h001234);
    wait_read(10);
    tick();
    pop_check("simul_pop");
    for (int i = 0; i < 3; i++) pop_check("simul_order");
    chk("simul_count3_empty", {31'b0, sampleReady}, 32'd0);

    // Reset with the FIFO half full and a codec sample waiting.
    for (int i = 0; i < DEPTH / 2; i++) begin
      rnd = $urandom();
      enqueue(rnd[31:8], rnd[23:0]);
    end
    repeat (15) tick();
    chk("half_full_ready", {31'b0, sampleReady}, 32'd1);
    rst = 1'b1;
    sb.delete();
    level_m = 0;
    enqueue(24'h012300, 24'h004500);
    tick();
    chk("mid_rst_sampleReady", {31'b0, sampleReady}, 32'd0);
    chk("mid_rst_level",       {22'b0, level},       32'd0);
    chk("mid_rst_overflow",    {31'b0, overflow},    32'd0);
    chk("mid_rst_codecRead",   {31'b0, codecRead},   32'd0);
    tick();
    chk("mid_rst_codecRead2",  {31'b0, codecRead},   32'd0);
    rst = 1'b0;
    wait_read(10);
    tick();
    tick();
    pop_check("post_rst_sample");
    chk("post_rst_empty", {31'b0, sampleReady}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
